// File: rtl/avmm_sram_controller_pkg.sv
// Shared definitions for the Avalon-MM to async 16-bit SRAM bridge:
// FSM encoding, data widths and a byte-lane strobe helper.
package avmm_sram_controller_pkg;

  localparam int AVS_DW  = 32;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Active-low {ub_n, lb_n} for one halfword: writes follow the byte
  // enables, reads always enable both lanes.
  function automatic logic [1:0] lanes_n(input logic wr, input logic [1:0] be2);
    return wr ? ~be2 : 2'b00;
  endfunction

endpackage

// File: rtl/avmm_sram_controller.sv
// Avalon-MM slave that splits each 32-bit access into two fixed-latency
// 16-bit accesses (lower halfword, then upper) on an asynchronous SRAM.
module avmm_sram_controller
  import avmm_sram_controller_pkg::*;
#(
  parameter int AVS_AW = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AVS_AW-1:0]   avs_address,
  input  logic [3:0]          avs_byteenable,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [AVS_DW-1:0]   avs_writedata,
  output logic [AVS_DW-1:0]   avs_readdata,
  output logic [AVS_AW-2:0]   sram_addr,
  output logic [SRAM_DW-1:0]  sram_writedata,
  input  logic [SRAM_DW-1:0]  sram_readdata,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n,
  output logic [1:0]          dbg_state
);

  localparam int SRAM_AW = AVS_AW - 1;
  localparam int WA_W    = AVS_AW - 2;

  // Request semantics: avs_read/avs_write are single-cycle pulses accepted
  // only in IDLE (write wins when both are high); there is no waitrequest,
  // the access always takes three cycles and readdata is valid after the
  // third edge. Pulses arriving while busy are dropped.

  state_t               state, state_nx;
  logic                 op_wr_q, op_wr_nx;
  logic [WA_W-1:0]      waddr_q, waddr_nx;
  logic [3:0]           be_q, be_nx;
  logic [AVS_DW-1:0]    wdata_q, wdata_nx;
  logic [SRAM_DW-1:0]   hold_q;

  logic [SRAM_AW-1:0]   addr_nx;
  logic [SRAM_DW-1:0]   wd_nx;
  logic                 ce_nx, oe_nx, we_nx, ub_nx, lb_nx;

  logic                 unused_addr_bits;
  assign unused_addr_bits = ^avs_address[1:0];

  assign dbg_state = state;

  // SRAM pins are registered, so the LOW-cycle values are computed from the
  // incoming request while still in IDLE.
  always_comb begin
    state_nx = state;
    op_wr_nx = op_wr_q;
    waddr_nx = waddr_q;
    be_nx    = be_q;
    wdata_nx = wdata_q;
    addr_nx  = '0;
    wd_nx    = '0;
    ce_nx    = 1'b1;
    oe_nx    = 1'b1;
    we_nx    = 1'b1;
    ub_nx    = 1'b1;
    lb_nx    = 1'b1;
    case (state)
      ST_IDLE: begin
        if (avs_read || avs_write) begin
          state_nx         = ST_LOW;
          op_wr_nx         = avs_write;
          waddr_nx         = avs_address[AVS_AW-1:2];
          be_nx            = avs_byteenable;
          wdata_nx         = avs_writedata;
          addr_nx          = {avs_address[AVS_AW-1:2], 1'b0};
          ce_nx            = 1'b0;
          {ub_nx, lb_nx}   = lanes_n(avs_write, avs_byteenable[1:0]);
          if (avs_write) begin
            we_nx = 1'b0;
            wd_nx = avs_writedata[15:0];
          end else begin
            oe_nx = 1'b0;
          end
        end
      end
      ST_LOW: begin
        state_nx       = ST_HIGH;
        addr_nx        = {waddr_q, 1'b1};
        ce_nx          = 1'b0;
        {ub_nx, lb_nx} = lanes_n(op_wr_q, be_q[3:2]);
        if (op_wr_q) begin
          we_nx = 1'b0;
          wd_nx = wdata_q[31:16];
        end else begin
          oe_nx = 1'b0;
        end
      end
      ST_HIGH: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      op_wr_q        <= 1'b0;
      waddr_q        <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      sram_addr      <= '0;
      sram_writedata <= '0;
      sram_ce_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      sram_ub_n      <= 1'b1;
      sram_lb_n      <= 1'b1;
    end else begin
      state          <= state_nx;
      op_wr_q        <= op_wr_nx;
      waddr_q        <= waddr_nx;
      be_q           <= be_nx;
      wdata_q        <= wdata_nx;
      sram_addr      <= addr_nx;
      sram_writedata <= wd_nx;
      sram_ce_n      <= ce_nx;
      sram_oe_n      <= oe_nx;
      sram_we_n      <= we_nx;
      sram_ub_n      <= ub_nx;
      sram_lb_n      <= lb_nx;
    end
  end

  // Lower halfword is parked at the end of LOW; the word is assembled when
  // the upper halfword arrives at the end of HIGH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q       <= '0;
      avs_readdata <= '0;
    end else begin
      if (state == ST_LOW && !op_wr_q) begin
        hold_q <= sram_readdata;
      end
      if (state == ST_HIGH && !op_wr_q) begin
        avs_readdata <= {sram_readdata, hold_q};
      end
    end
  end

endmodule

// File: tb/tb_avmm_sram_controller.sv
// Directed plus randomized bench for avmm_sram_controller, with a word-level
// reference memory and a byte-lane SRAM pin model.
module tb_avmm_sram_controller;
  import avmm_sram_controller_pkg::*;

  logic        clk;
  logic        reset;
  logic [18:0] avs_address;
  logic [3:0]  avs_byteenable;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [17:0] sram_addr;
  logic [15:0] sram_writedata;
  logic [15:0] sram_readdata;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] ref_words [int];
  logic [31:0] exp_readdata;

  avmm_sram_controller dut (
    .clk            (clk),
    .reset          (reset),
    .avs_address    (avs_address),
    .avs_byteenable (avs_byteenable),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .sram_addr      (sram_addr),
    .sram_writedata (sram_writedata),
    .sram_readdata  (sram_readdata),
    .sram_ce_n      (sram_ce_n),
    .sram_oe_n      (sram_oe_n),
    .sram_we_n      (sram_we_n),
    .sram_ub_n      (sram_ub_n),
    .sram_lb_n      (sram_lb_n),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // asynchronous SRAM: reads are combinational, writes land mid-cycle
  assign sram_readdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  <= sram_writedata[7:0];
      if (!sram_ub_n) sram_mem[sram_addr][15:8] <= sram_writedata[15:8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [18:0] addr);
    int idx = int'(addr[18:2]);
    return ref_words.exists(idx) ? ref_words[idx] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] w = old;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = data[8*b +: 8];
    return w;
  endfunction

  // Expected {ce_n, oe_n, we_n, ub_n, lb_n} for the active halfword.
  function automatic logic [4:0] exp_pins(input logic wr, input logic [1:0] be2);
    if (wr) return {1'b0, 1'b1, 1'b0, ~be2[1], ~be2[0]};
    return 5'b00100;
  endfunction

  function automatic logic [4:0] pins();
    return {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    chk({tag, "_pins"}, 32'(pins()), 32'h1f);
    chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
    chk({tag, "_wdata"}, 32'(sram_writedata), 32'h0);
  endtask

  // One bus access; optionally pulses avs_read during the LOW cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [18:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           input logic inject_rd);
    @(negedge clk);
    avs_address    = addr;
    avs_read       = rd;
    avs_write      = wr;
    avs_writedata  = data;
    avs_byteenable = be;
    @(negedge clk);
    avs_read       = inject_rd;
    avs_write      = 1'b0;
    avs_address    = 19'($urandom);
    avs_writedata  = $urandom;
    avs_byteenable = 4'($urandom);
    chk("low_state", 32'(dbg_state), 32'(ST_LOW));
    chk("low_pins", 32'(pins()), 32'(exp_pins(wr, wr ? be[1:0] : 2'b00)));
    chk("low_addr", 32'(sram_addr), 32'({addr[18:2], 1'b0}));
    if (wr) chk("low_wdata", 32'(sram_writedata), 32'(data[15:0]));
    @(negedge clk);
    avs_read = 1'b0;
    chk("high_state", 32'(dbg_state), 32'(ST_HIGH));
    chk("high_pins", 32'(pins()), 32'(exp_pins(wr, wr ? be[3:2] : 2'b00)));
    chk("high_addr", 32'(sram_addr), 32'({addr[18:2], 1'b1}));
    if (wr) chk("high_wdata", 32'(sram_writedata), 32'(data[31:16]));
    @(negedge clk);
    if (wr) ref_words[int'(addr[18:2])] = merge(ref_read(addr), data, be);
    else exp_readdata = ref_read(addr);
    chk(wr ? "readdata_after_write" : "readdata", avs_readdata, exp_readdata);
    check_idle("done");
  endtask

  task automatic do_write(input logic [18:0] addr, input logic [31:0] data, input logic [3:0] be);
    do_access(1'b0, 1'b1, addr, data, be, 1'b0);
  endtask

  task automatic do_read(input logic [18:0] addr);
    do_access(1'b1, 1'b0, addr, $urandom, 4'($urandom), 1'b0);
  endtask

  initial begin
    logic [18:0] a;
    reset          = 1'b0;
    avs_address    = '0;
    avs_byteenable = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    exp_readdata   = 32'h0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_readdata", avs_readdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // full word write and read
    do_write(19'h0, 32'hCCCC0123, 4'b1111);
    chk("sram0", 32'(sram_mem[0]), 32'h0123);
    chk("sram1", 32'(sram_mem[1]), 32'hCCCC);
    do_read(19'h0);
    chk("word0", avs_readdata, 32'hCCCC0123);

    // multiple addresses, shuffled readback
    do_write(19'h4,  32'hBBBBAAAA, 4'b1111);
    do_write(19'h8,  32'h12344567, 4'b1111);
    do_write(19'hC,  32'h0000ABCD, 4'b1111);
    do_write(19'h20, 32'hDEADBEEF, 4'b1111);
    do_read(19'h0);
    do_read(19'h8);
    chk("word8", avs_readdata, 32'h12344567);
    do_read(19'h20);
    do_read(19'hC);
    do_read(19'h4);
    chk("word4", avs_readdata, 32'hBBBBAAAA);

    // lower halfword mask
    do_write(19'h20, 32'h0000FFFF, 4'b0011);
    do_read(19'h20);
    chk("word20_masked", avs_readdata, 32'hDEADFFFF);

    // single byte mask; reads ignore byteenable
    do_write(19'h10, 32'h12345678, 4'b1111);
    do_write(19'h10, 32'hFF345678, 4'b1000);
    do_access(1'b1, 1'b0, 19'h10, 32'h0, 4'b0011, 1'b0);
    chk("word10_byte", avs_readdata, 32'hFF345678);

    // read pulse while busy is dropped; read+write executes as write
    do_access(1'b0, 1'b1, 19'h14, 32'hA5A55A5A, 4'b1111, 1'b1);
    @(negedge clk);
    check_idle("busy_read_dropped");
    do_access(1'b1, 1'b1, 19'h18, 32'h0BADF00D, 4'b1111, 1'b0);
    chk("readdata_kept", avs_readdata, 32'hFF345678);
    do_read(19'h18);
    chk("word18_prio", avs_readdata, 32'h0BADF00D);
    do_read(19'h14);

    // asynchronous reset during HIGH of a write
    @(negedge clk);
    avs_address = 19'h30; avs_write = 1'b1; avs_writedata = 32'h77778888;
    avs_byteenable = 4'b1111;
    @(negedge clk);
    avs_write = 1'b0;
    @(negedge clk);
    chk("rst_in_high", 32'(dbg_state), 32'(ST_HIGH));
    #2 reset = 1'b0;
    #1;
    check_idle("async_reset");
    chk("async_reset_readdata", avs_readdata, 32'h0);
    exp_readdata = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    do_write(19'h34, 32'h13579BDF, 4'b1111);
    do_read(19'h34);
    chk("after_reset", avs_readdata, 32'h13579BDF);

    // randomized traffic against the word-level reference
    for (int i = 0; i < 8; i++) do_write(19'(32'h40 + 4 * i), $urandom, 4'b1111);
    for (int i = 0; i < 32; i++) begin
      a = 19'(32'h40 + 4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom));
      else do_read(a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avmm_sram_controller.md
Name: avmm_sram_controller

Overview:
- Avalon-MM slave bridging a 32-bit byte-addressed bus to an external asynchronous 256K x 16 SRAM (IS61WV25616-class).
- Each bus word access is split into two 16-bit SRAM accesses: lower halfword first, then upper.
- Fixed latency, no waitrequest. Sits between the system interconnect and the board SRAM pins; tristate merging of the data bus is done at the top level.

Parameters:
- AVS_AW, 19, Avalon byte-address width; localparam SRAM_AW = AVS_AW-1 (18).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- avs_address  in  19  byte address; bits [1:0] ignored
- avs_byteenable  in  4  byte lanes for writes
- avs_read  in  1  read request, single-cycle pulse
- avs_write  in  1  write request, single-cycle pulse
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- sram_addr  out  18  SRAM halfword address
- sram_writedata  out  16  data driven to SRAM
- sram_readdata  in  16  data from SRAM
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_ub_n  out  1  upper byte enable, active low
- sram_lb_n  out  1  lower byte enable, active low

Behaviour:
- Reset values (also the idle values):
  - all sram_*_n = 1
  - sram_addr = 0, sram_writedata = 0, avs_readdata = 0
  - FSM = IDLE
- FSM states and transitions:
  - IDLE -> LOW when avs_read or avs_write is sampled high.
  - LOW -> HIGH unconditionally.
  - HIGH -> IDLE unconditionally.
- Request handling:
  - Requests are sampled only in IDLE; requests arriving in LOW or HIGH are ignored.
  - Masters must space requests at least 3 cycles apart.
  - If read and write are sampled high together, the write wins.
- Latched on acceptance: word address avs_address[18:2], byteenable, writedata, and the operation type.
- LOW cycle (lower halfword):
  - sram_addr = {addr[18:2],1'b0}; ce_n = 0.
  - Write: we_n = 0, oe_n = 1, sram_writedata = wdata[15:0], lb_n = ~be[0], ub_n = ~be[1].
  - Read: oe_n = 0, we_n = 1, lb_n = ub_n = 0.
- HIGH cycle (upper halfword):
  - sram_addr = {addr[18:2],1'b1}.
  - Write: sram_writedata = wdata[31:16], lb_n = ~be[2], ub_n = ~be[3].
  - Read: same as LOW.
- All SRAM outputs are registered. Address, data, byte enables and we_n change on the same edge and are held for the full cycle.
- A halfword with both enables 0 still occupies its cycle with lb_n = ub_n = 1; latency is fixed.
- Read data path:
  - sram_readdata is captured into a holding register at the end of LOW.
  - avs_readdata = {sram_readdata, hold} is loaded at the end of HIGH.
  - Reads ignore avs_byteenable and always return the full 32-bit word.
  - avs_readdata holds its value until the next read completes; writes do not change it.
- Latency:
  - Request sampled at edge N: LOW occupies N..N+1, HIGH occupies N+1..N+2.
  - avs_readdata is valid just after edge N+2.
  - Back in IDLE after N+2; next request is accepted at N+3.
- Reset mid-operation: return to IDLE immediately; outputs go to idle values; the partial write is not completed.

Decomposition:
- Small shared package: FSM state encoding (IDLE/LOW/HIGH) and the width constants.
- No sub-module; a single flat module is natural.

Test Plan:
- Full write/read: write 0x0 <= 0xCCCC0123 be=1111, then read 0x0.
  - SRAM[0] = 0x0123, SRAM[1] = 0xCCCC; readdata = 0xCCCC0123 at N+2.
- Multiple addresses: write 0x4 = 0xBBBBAAAA, 0x8 = 0x12344567, 0xC = 0x0000ABCD, 0x20 = 0xDEADBEEF; read back in shuffled order (0x0, 0x8, 0x20, 0xC, 0x4).
  - Each read returns its written value.
- Lower halfword mask: write 0x20 = 0x0000FFFF be=0011.
  - Read 0x20 = 0xDEADFFFF.
- Single byte mask: write 0x10 = 0x12345678 be=1111, then 0x10 = 0xFF345678 be=1000.
  - Only ub_n of the HIGH cycle is asserted.
  - Read 0x10 with be=0011 returns full word 0xFF345678.
- Busy and priority:
  - A read pulse arriving during LOW/HIGH of a write is ignored.
  - Simultaneous read+write is executed as a write.
  - avs_readdata is unchanged after writes.
- Reset: reset asserted during HIGH of a write.
  - All SRAM strobes go to 1 asynchronously and the FSM returns to IDLE.
  - After release, a new access works normally.
